p5_16_state_monitor: RTL and testbench

//  Downstream checker for the Problem 5.16 two-flip-flop sequential circuit (A,B,x_in).
//  - Samples the DUT state {A,B} and x_in every clock and predicts the next state

---
 rtl/p5_16_state_monitor.sv | 188 ++++++++++++++++++
 tb/tb_p5_16_state_monitor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/p5_16_state_monitor.sv
// -----------------------------------------------------------------------------
// p5_16_state_monitor
//
// Purpose:
//   Downstream checker for the Problem 5.16 two-flip-flop circuit (A, B, x).
//   Every clock it samples {A,B,x} and predicts the next {A,B} from
//     D_A = ~B&~x | A&x
//     D_B =  B&x  | A&~x
//   On the following edge it compares the observed state against that
//   prediction. It flags mismatches, counts completed 00->10->11->01
//   rotations and correct x=1 holds, and latches into a sticky FAIL state
//   once ERR_LIMIT mismatches have been seen.
//
// Parameters:
//   CNT_W      width of the err/rot/hold counters (all saturate at all-ones)
//   ERR_LIMIT  mismatch count that drives the monitor into FAIL
//              (1 .. 2**CNT_W-1)
//
// Ports:
//   i_clock        rising-edge clock shared with the monitored circuit
//   i_reset        synchronous active-high reset, clears everything
//   i_clear        synchronous soft clear, same effect as reset
//   i_x_in         circuit input x
//   i_state_a      circuit flip-flop A
//   i_state_b      circuit flip-flop B
//   o_err_pulse    one-cycle high on each counted mismatch
//   o_fail         high while the monitor is in FAIL
//   o_mon_state    00 IDLE, 01 TRACK, 10 FAIL
//   o_err_count    mismatches since reset/clear
//   o_rot_count    completed rotations
//   o_hold_count   correct x=1 hold transitions
//   o_last_exp     {A,B} expected at the last counted mismatch
//   o_last_obs     {A,B} observed at the last counted mismatch
//
// Build option:
//   P5_16_MON_CAPTURE_EN  when defined, o_last_exp/o_last_obs are captured
//                         on each counted mismatch; otherwise they are 2'b00.
// -----------------------------------------------------------------------------
module p5_16_state_monitor #(
    parameter int CNT_W     = 8,
    parameter int ERR_LIMIT = 3
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_x_in,
    input  logic             i_state_a,
    input  logic             i_state_b,
    output logic             o_err_pulse,
    output logic             o_fail,
    output logic [1:0]       o_mon_state,
    output logic [CNT_W-1:0] o_err_count,
    output logic [CNT_W-1:0] o_rot_count,
    output logic [CNT_W-1:0] o_hold_count,
    output logic [1:0]       o_last_exp,
    output logic [1:0]       o_last_obs
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAIL  = 2'b10
    } mon_state_t;

    // Saturating increment shared by all three counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    mon_state_t       r_state;
    logic             r_samp_a;
    logic             r_samp_b;
    logic             r_samp_x;
    logic [1:0]       r_run;
    logic             r_err_pulse;
    logic             r_fail;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_rot_cnt;
    logic [CNT_W-1:0] r_hold_cnt;

    logic             w_clr;
    logic [1:0]       w_exp;
    logic [1:0]       w_obs;
    logic             w_mismatch;
    logic             w_count_err;
    logic [CNT_W-1:0] w_err_next;

    assign w_clr       = i_reset | i_clear;
    // Next state predicted from the previous sample.
    assign w_exp       = {(~r_samp_b & ~r_samp_x) | (r_samp_a & r_samp_x),
                          ( r_samp_b &  r_samp_x) | (r_samp_a & ~r_samp_x)};
    assign w_obs       = {i_state_a, i_state_b};
    assign w_mismatch  = (w_exp != w_obs);
    // Only mismatches seen while tracking count; clear/reset take priority.
    assign w_count_err = (r_state == ST_TRACK) && w_mismatch && !w_clr;
    assign w_err_next  = sat_inc(r_err_cnt);

    always_ff @(posedge i_clock) begin
        if (w_clr) begin
            r_state     <= ST_IDLE;
            r_samp_a    <= 1'b0;
            r_samp_b    <= 1'b0;
            r_samp_x    <= 1'b0;
            r_run       <= 2'd0;
            r_err_pulse <= 1'b0;
            r_fail      <= 1'b0;
            r_err_cnt   <= '0;
            r_rot_cnt   <= '0;
            r_hold_cnt  <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // First sample after reset/clear is captured, never checked.
                    r_samp_a <= i_state_a;
                    r_samp_b <= i_state_b;
                    r_samp_x <= i_x_in;
                    r_state  <= ST_TRACK;
                end
                ST_TRACK: begin
                    r_samp_a <= i_state_a;
                    r_samp_b <= i_state_b;
                    r_samp_x <= i_x_in;
                    if (w_mismatch) begin
                        r_err_pulse <= 1'b1;
                        r_err_cnt   <= w_err_next;
                        r_run       <= 2'd0;
                        if (w_err_next == CNT_W'(ERR_LIMIT)) begin
                            r_state <= ST_FAIL;
                            r_fail  <= 1'b1;
                        end
                    end else if (!r_samp_x) begin
                        // Fourth consecutive advance closes a rotation.
                        if (r_run == 2'd3) begin
                            r_run     <= 2'd0;
                            r_rot_cnt <= sat_inc(r_rot_cnt);
                        end else begin
                            r_run <= r_run + 2'd1;
                        end
                    end else begin
                        // Holds leave the run counter alone.
                        r_hold_cnt <= sat_inc(r_hold_cnt);
                    end
                end
                ST_FAIL: begin
                    // Sticky: everything frozen until reset or clear.
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef P5_16_MON_CAPTURE_EN
    logic [1:0] r_last_exp;
    logic [1:0] r_last_obs;

    always_ff @(posedge i_clock) begin
        if (w_clr) begin
            r_last_exp <= 2'b00;
            r_last_obs <= 2'b00;
        end else if (w_count_err) begin
            r_last_exp <= w_exp;
            r_last_obs <= w_obs;
        end
    end

    assign o_last_exp = r_last_exp;
    assign o_last_obs = r_last_obs;
`else
    logic w_unused_capture;
    assign w_unused_capture = w_count_err;
    assign o_last_exp = 2'b00;
    assign o_last_obs = 2'b00;
`endif

    assign o_err_pulse  = r_err_pulse;
    assign o_fail       = r_fail;
    assign o_mon_state  = r_state;
    assign o_err_count  = r_err_cnt;
    assign o_rot_count  = r_rot_cnt;
    assign o_hold_count = r_hold_cnt;

endmodule

// File: tb/tb_p5_16_state_monitor.sv
// -----------------------------------------------------------------------------
// tb_p5_16_state_monitor
//
// Bench for p5_16_state_monitor. A table of per-cycle vectors (inputs plus
// expected outputs after the edge) covers rotation, hold and single-fault
// behaviour; short hand-written sequences cover FAIL/clear, reset during a
// rotation and counter saturation (second instance with CNT_W=2).
// -----------------------------------------------------------------------------
module tb_p5_16_state_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       x   = 1'b0;
    logic       a   = 1'b0;
    logic       b   = 1'b0;

    logic       pulse, fail;
    logic [1:0] mst, lexp, lobs;
    logic [7:0] errc, rotc, holdc;

    logic       pulse2, fail2;
    logic [1:0] mst2, lexp2, lobs2;
    logic [1:0] errc2, rotc2, holdc2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    p5_16_state_monitor #(.CNT_W(8), .ERR_LIMIT(3)) dut (
        .i_clock(clk), .i_reset(rst), .i_clear(clr), .i_x_in(x),
        .i_state_a(a), .i_state_b(b),
        .o_err_pulse(pulse), .o_fail(fail), .o_mon_state(mst),
        .o_err_count(errc), .o_rot_count(rotc), .o_hold_count(holdc),
        .o_last_exp(lexp), .o_last_obs(lobs)
    );

    p5_16_state_monitor #(.CNT_W(2), .ERR_LIMIT(3)) dut2 (
        .i_clock(clk), .i_reset(rst), .i_clear(clr), .i_x_in(x),
        .i_state_a(a), .i_state_b(b),
        .o_err_pulse(pulse2), .o_fail(fail2), .o_mon_state(mst2),
        .o_err_count(errc2), .o_rot_count(rotc2), .o_hold_count(holdc2),
        .o_last_exp(lexp2), .o_last_obs(lobs2)
    );

    typedef struct {
        logic       rst, clr, x, a, b;
        logic       pulse;
        logic [1:0] st;
        int         err, rot, hold;
        logic [1:0] lexp, lobs;   // values with capture enabled
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Apply one set of inputs for one rising edge; outputs are sampled 1ns later.
    task automatic step(input logic r, input logic c, input logic xi, input logic ai, input logic bi);
        @(negedge clk);
        rst = r; clr = c; x = xi; a = ai; b = bi;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] cap(input logic [1:0] v);
`ifdef P5_16_MON_CAPTURE_EN
        return v;
`else
        return (v == 2'b11) ? 2'b00 : 2'b00;
`endif
    endfunction

    task automatic add(input logic r, input logic c, input logic xi, input logic ai, input logic bi,
                       input logic p, input logic [1:0] s, input int e, input int ro, input int h,
                       input logic [1:0] le, input logic [1:0] lo);
        vec_t v;
        v.rst = r; v.clr = c; v.x = xi; v.a = ai; v.b = bi;
        v.pulse = p; v.st = s; v.err = e; v.rot = ro; v.hold = h;
        v.lexp = le; v.lobs = lo;
        vecs.push_back(v);
    endtask

    initial begin
        // ---- rotation with x=0: 00,10,11,01,00,10,11,01,00 ----
        add(1,0,0,0,0, 0,2'b00,0,0,0, 2'b00,2'b00);
        add(0,0,0,0,0, 0,2'b01,0,0,0, 2'b00,2'b00);
        add(0,0,0,1,0, 0,2'b01,0,0,0, 2'b00,2'b00);
        add(0,0,0,1,1, 0,2'b01,0,0,0, 2'b00,2'b00);
        add(0,0,0,0,1, 0,2'b01,0,0,0, 2'b00,2'b00);
        add(0,0,0,0,0, 0,2'b01,0,1,0, 2'b00,2'b00);
        add(0,0,0,1,0, 0,2'b01,0,1,0, 2'b00,2'b00);
        add(0,0,0,1,1, 0,2'b01,0,1,0, 2'b00,2'b00);
        add(0,0,0,0,1, 0,2'b01,0,1,0, 2'b00,2'b00);
        add(0,0,0,0,0, 0,2'b01,0,2,0, 2'b00,2'b00);
        // ---- holds at 11, then advances back to 11 ----
        add(1,0,1,1,1, 0,2'b00,0,0,0, 2'b00,2'b00);
        add(0,0,1,1,1, 0,2'b01,0,0,0, 2'b00,2'b00);
        add(0,0,1,1,1, 0,2'b01,0,0,1, 2'b00,2'b00);
        add(0,0,1,1,1, 0,2'b01,0,0,2, 2'b00,2'b00);
        add(0,0,1,1,1, 0,2'b01,0,0,3, 2'b00,2'b00);
        add(0,0,1,1,1, 0,2'b01,0,0,4, 2'b00,2'b00);
        add(0,0,0,1,1, 0,2'b01,0,0,5, 2'b00,2'b00);
        add(0,0,0,0,1, 0,2'b01,0,0,5, 2'b00,2'b00);
        add(0,0,0,0,0, 0,2'b01,0,0,5, 2'b00,2'b00);
        add(0,0,0,1,0, 0,2'b01,0,0,5, 2'b00,2'b00);
        add(0,0,0,1,1, 0,2'b01,0,1,5, 2'b00,2'b00);
        // ---- holds inserted in the middle of a rotation ----
        add(0,0,1,0,1, 0,2'b01,0,1,5, 2'b00,2'b00);
        add(0,0,1,0,1, 0,2'b01,0,1,6, 2'b00,2'b00);
        add(0,0,0,0,1, 0,2'b01,0,1,7, 2'b00,2'b00);
        add(0,0,0,0,0, 0,2'b01,0,1,7, 2'b00,2'b00);
        add(0,0,0,1,0, 0,2'b01,0,1,7, 2'b00,2'b00);
        add(0,0,0,1,1, 0,2'b01,0,2,7, 2'b00,2'b00);
        // ---- single fault: expected 11, observed 00 after three advances ----
        add(0,0,0,0,1, 0,2'b01,0,2,7, 2'b00,2'b00);
        add(0,0,0,0,0, 0,2'b01,0,2,7, 2'b00,2'b00);
        add(0,0,0,1,0, 0,2'b01,0,2,7, 2'b00,2'b00);
        add(0,0,0,0,0, 1,2'b01,1,2,7, 2'b11,2'b00);
        add(0,0,0,1,0, 0,2'b01,1,2,7, 2'b11,2'b00);
        add(0,0,0,1,1, 0,2'b01,1,2,7, 2'b11,2'b00);
        add(0,0,0,0,1, 0,2'b01,1,2,7, 2'b11,2'b00);
        add(0,0,0,0,0, 0,2'b01,1,3,7, 2'b11,2'b00);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].clr, vecs[i].x, vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d pulse", i), pulse, vecs[i].pulse);
            chk($sformatf("vec%0d state", i), mst,   vecs[i].st);
            chk($sformatf("vec%0d fail", i),  fail,  0);
            chk($sformatf("vec%0d err", i),   errc,  vecs[i].err);
            chk($sformatf("vec%0d rot", i),   rotc,  vecs[i].rot);
            chk($sformatf("vec%0d hold", i),  holdc, vecs[i].hold);
            chk($sformatf("vec%0d lexp", i),  lexp,  cap(vecs[i].lexp));
            chk($sformatf("vec%0d lobs", i),  lobs,  cap(vecs[i].lobs));
        end

        // ---- three mismatches reach FAIL, FAIL is sticky, clear exits ----
        step(1,0,0,0,0);
        step(0,0,0,0,0);
        step(0,0,0,0,0);
        chk("fail m1 pulse", pulse, 1); chk("fail m1 err", errc, 1); chk("fail m1 state", mst, 2'b01);
        step(0,0,0,0,0);
        chk("fail m2 err", errc, 2); chk("fail m2 fail", fail, 0);
        step(0,0,0,0,0);
        chk("fail m3 pulse", pulse, 1); chk("fail m3 err", errc, 3);
        chk("fail m3 state", mst, 2'b10); chk("fail m3 fail", fail, 1);
        chk("fail m3 lexp", lexp, cap(2'b10)); chk("fail m3 lobs", lobs, cap(2'b00));
        step(0,0,0,0,1);
        chk("fail m4 pulse", pulse, 0); chk("fail m4 err", errc, 3);
        chk("fail m4 state", mst, 2'b10); chk("fail m4 lobs", lobs, cap(2'b00));
        step(0,1,0,0,0);
        chk("clear state", mst, 2'b00); chk("clear fail", fail, 0);
        chk("clear err", errc, 0); chk("clear rot", rotc, 0); chk("clear hold", holdc, 0);
        chk("clear lexp", lexp, 0);

        // ---- clear together with a mismatch: clear wins ----
        step(0,0,0,0,0);
        chk("clrmis track", mst, 2'b01);
        step(0,1,0,0,0);
        chk("clrmis pulse", pulse, 0); chk("clrmis err", errc, 0); chk("clrmis state", mst, 2'b00);
        step(0,0,0,0,0);
        step(0,0,0,0,0);
        chk("clrmis after pulse", pulse, 1);

        // ---- reset mid-rotation; first post-reset sample unchecked ----
        step(1,0,0,0,0);
        step(0,0,0,0,0);
        step(0,0,0,1,0);
        step(0,0,0,1,1);
        chk("midrst pre state", mst, 2'b01);
        step(1,0,0,0,1);
        chk("midrst state", mst, 2'b00); chk("midrst err", errc, 0); chk("midrst pulse", pulse, 0);
        step(0,0,0,1,0);
        chk("midrst first pulse", pulse, 0); chk("midrst first state", mst, 2'b01);
        step(0,0,0,1,1);
        step(0,0,0,0,1);
        step(0,0,0,0,0);
        chk("midrst 3adv rot", rotc, 0); chk("midrst 3adv err", errc, 0);
        step(0,0,0,1,0);
        chk("midrst 4adv rot", rotc, 1);

        // ---- saturation: 5 rotations into a 2-bit counter ----
        step(1,0,0,0,0);
        step(0,0,0,0,0);
        for (int r = 0; r < 5; r++) begin
            step(0,0,0,1,0);
            step(0,0,0,1,1);
            step(0,0,0,0,1);
            step(0,0,0,0,0);
        end
        chk("sat rot2", rotc2, 3); chk("sat err2", errc2, 0);
        chk("sat rot8", rotc, 5); chk("sat state2", mst2, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
